pkt_hdr_vec_builder: RTL and testbench

Ingress-side builder of the packet header vector (PHV). It snoops the accepted AXI-Stream beats of each packet and captures the first four 256-bit beats into a 1024-bit segment field. It also counts the valid bytes in those beats and emits one fixed-layout PHV per packet as a single-cycle valid pulse into the PHV FIFO. The t_process reassembly stage downstream reads that FIFO to rebuild and trim the packet.

---
 rtl/pkt_hdr_vec_builder.sv | 143 ++++++++++++++
 tb/tb_pkt_hdr_vec_builder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_hdr_vec_builder.sv
// Packet header vector builder: snoops accepted AXI-Stream beats, captures the first four
// beats with byte masking, counts their valid bytes and emits one PHV strobe per packet.
module pkt_hdr_vec_builder #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int PKT_VEC_WIDTH        = 1735
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              phv_valid,
    output logic [PKT_VEC_WIDTH-1:0]          pkt_hdr_vec,
    output logic [31:0]                       phv_cnt
);

    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int KW    = DW / 8;
    localparam int PW    = $clog2(KW) + 1;
    localparam int SEG_W = 4 * DW;
    localparam int PAD_W = PKT_VEC_WIDTH - SEG_W - 7 - C_S_AXIS_TUSER_WIDTH;
    localparam logic [PAD_W-1:0] PAD_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN
    } state_t;

    state_t                            r_state;
    state_t                            w_state_next;
    logic [1:0]                        r_idx;
    logic [1:0]                        w_idx;
    logic [SEG_W-1:0]                  r_seg;
    logic [SEG_W-1:0]                  w_seg_next;
    logic [7:0]                        r_len;
    logic [7:0]                        w_len_next;
    logic [6:0]                        w_len_sat;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   r_tuser;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   w_tuser_next;
    logic [DW-1:0]                     w_masked;
    logic [PW-1:0]                     w_pop;
    logic                              w_capture;
    logic                              w_emit;

    // State register
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (s_axis_tvalid) begin
            case (r_state)
                S_IDLE:  w_state_next = s_axis_tlast ? S_IDLE : S_ACCUM;
                S_ACCUM: begin
                    if (s_axis_tlast)       w_state_next = S_IDLE;
                    else if (r_idx == 2'd3) w_state_next = S_DRAIN;
                    else                    w_state_next = S_ACCUM;
                end
                S_DRAIN: w_state_next = s_axis_tlast ? S_IDLE : S_DRAIN;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Output decode: which accepted beats are captured and which complete a PHV
    always_comb begin
        w_capture = 1'b0;
        w_emit    = 1'b0;
        if (s_axis_tvalid) begin
            case (r_state)
                S_IDLE: begin
                    w_capture = 1'b1;
                    w_emit    = s_axis_tlast;
                end
                S_ACCUM: begin
                    w_capture = 1'b1;
                    w_emit    = s_axis_tlast || (r_idx == 2'd3);
                end
                default: begin
                    w_capture = 1'b0;
                    w_emit    = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_masked = '0;
        w_pop    = '0;
        for (int unsigned i = 0; i < KW; i++) begin
            w_masked[8*i +: 8] = s_axis_tkeep[i] ? s_axis_tdata[8*i +: 8] : 8'h00;
            w_pop              = w_pop + {{(PW-1){1'b0}}, s_axis_tkeep[i]};
        end
    end

    // The completed vector includes the current beat so a PHV can be emitted the
    // cycle after its last beat while the next packet starts in a cleared vector.
    always_comb begin
        w_idx        = (r_state == S_IDLE) ? 2'd0 : r_idx;
        w_seg_next   = (r_state == S_IDLE) ? '0 : r_seg;
        w_seg_next[{w_idx, 8'd0} +: DW] = w_masked;
        w_len_next   = ((r_state == S_IDLE) ? 8'd0 : r_len) + {{(8-PW){1'b0}}, w_pop};
        w_len_sat    = w_len_next[7] ? 7'h7F : w_len_next[6:0];
        w_tuser_next = (r_state == S_IDLE) ? s_axis_tuser : r_tuser;
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_idx       <= '0;
            r_seg       <= '0;
            r_len       <= '0;
            r_tuser     <= '0;
            phv_valid   <= 1'b0;
            pkt_hdr_vec <= '0;
            phv_cnt     <= '0;
        end else begin
            phv_valid <= w_emit;
            if (s_axis_tvalid) begin
                r_idx <= (w_state_next == S_ACCUM) ? w_idx + 2'd1 : 2'd0;
            end
            if (w_capture) begin
                r_seg   <= w_seg_next;
                r_len   <= w_len_next;
                r_tuser <= w_tuser_next;
            end
            if (w_emit) begin
                pkt_hdr_vec <= {w_seg_next, w_len_sat, PAD_ZERO, w_tuser_next};
                phv_cnt     <= phv_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_hdr_vec_builder.sv
// Self-checking bench for pkt_hdr_vec_builder: packet-level reference model, per-cycle
// compare process, and literal checks on selected PHV fields.
module tb_pkt_hdr_vec_builder;

    logic           clk = 1'b0;
    logic           aresetn;
    logic [255:0]   s_axis_tdata;
    logic [31:0]    s_axis_tkeep;
    logic [127:0]   s_axis_tuser;
    logic           s_axis_tvalid;
    logic           s_axis_tlast;
    logic           phv_valid;
    logic [1734:0]  pkt_hdr_vec;
    logic [31:0]    phv_cnt;

    always #5 clk = ~clk;

    pkt_hdr_vec_builder #(
        .C_S_AXIS_DATA_WIDTH  (256),
        .C_S_AXIS_TUSER_WIDTH (128),
        .PKT_VEC_WIDTH        (1735)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .phv_valid     (phv_valid),
        .pkt_hdr_vec   (pkt_hdr_vec),
        .phv_cnt       (phv_cnt)
    );

    typedef struct {
        logic [1734:0] vec;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    int            n_chk = 0;
    int            n_bad = 0;
    int            cyc_n = 0;
    int            exp_cnt = 0;
    logic [1734:0] last_vec = '0;
    logic [31:0]   keep_tab[8];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cmp_vec(input string tag, input logic [1734:0] a, input logic [1734:0] e);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_seg%0d", tag, k), a[711+256*k +: 256], e[711+256*k +: 256]);
        chk({tag, "_len"},   256'(a[710:704]),  256'(e[710:704]));
        chk({tag, "_zero"},  256'(|a[703:128]), 256'(|e[703:128]));
        chk({tag, "_tuser"}, 256'(a[127:0]),    256'(e[127:0]));
    endtask

    function automatic logic [255:0] beat_data(input int pid, input int k);
        logic [255:0] d;
        for (int w = 0; w < 8; w++)
            d[32*w +: 32] = {pid[7:0], k[7:0], w[7:0], 8'h5A};
        return d;
    endfunction

    // Reference: PHV from whole-packet rules (first four beats masked, byte sum capped at 127)
    task automatic send_pkt(input int n, input logic [127:0] user, input int pid, input bit gap);
        exp_t          e;
        logic [1023:0] seg = '0;
        logic [255:0]  d;
        int            len = 0;
        int            nc  = (n < 4) ? n : 4;
        for (int k = 0; k < nc; k++) begin
            d = beat_data(pid, k);
            for (int b = 0; b < 32; b++)
                if (keep_tab[k][b]) seg[256*k + 8*b +: 8] = d[8*b +: 8];
            len += $countones(keep_tab[k]);
        end
        if (len > 127) len = 127;
        e.vec = {seg, 7'(len), 576'b0, user};
        e.cyc = 0;
        for (int k = 0; k < n; k++) begin
            if (gap && k > 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_axis_tdata  = beat_data(pid, k);
            s_axis_tkeep  = keep_tab[k];
            s_axis_tuser  = (k == 0) ? user : ~user;
            s_axis_tlast  = (k == n - 1);
            s_axis_tvalid = 1'b1;
            if (k == nc - 1) begin
                e.cyc = cyc_n;
                q.push_back(e);
            end
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic idle(input int c);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (c) begin
            @(posedge clk); #1;
        end
    endtask

    // Strobe is due at the second negedge after the completing beat is driven
    always @(negedge clk) begin
        exp_t e;
        cyc_n++;
        if (!aresetn) begin
            q.delete();
            exp_cnt  = 0;
            last_vec = '0;
        end else if (phv_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", 256'(phv_valid), 256'(0));
            end else begin
                e = q.pop_front();
                chk("strobe_cycle", 256'(cyc_n), 256'(e.cyc + 2));
                cmp_vec("phv", pkt_hdr_vec, e.vec);
                exp_cnt++;
                chk("phv_cnt", 256'(phv_cnt), 256'(exp_cnt));
                last_vec = e.vec;
            end
        end else begin
            chk("hold_vec", 256'(pkt_hdr_vec === last_vec), 256'(1));
            chk("hold_cnt", 256'(phv_cnt), 256'(exp_cnt));
            if (q.size() > 0 && cyc_n > q[0].cyc + 2) begin
                chk("missing_strobe", 256'(phv_valid), 256'(1));
                void'(q.pop_front());
            end
        end
    end

    initial begin
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_valid", 256'(phv_valid), 256'(0));
        chk("reset_vec",   256'(|pkt_hdr_vec), 256'(0));
        chk("reset_cnt",   256'(phv_cnt), 256'(0));
        @(posedge clk); #1;
        aresetn = 1'b1;
        idle(2);

        // single beat, 28 valid bytes
        keep_tab[0] = 32'h0FFF_FFFF;
        send_pkt(1, 128'h1111_2222_3333_4444_5555_6666_7777_88AB, 1, 1'b0);
        @(negedge clk);
        chk("A_valid",  256'(phv_valid), 256'(1));
        chk("A_len",    256'(pkt_hdr_vec[710:704]), 256'(28));
        chk("A_hibyte", 256'(pkt_hdr_vec[711+224 +: 32]), 256'(0));
        chk("A_seg123", 256'(|pkt_hdr_vec[1734:967]), 256'(0));
        chk("A_tuser",  256'(pkt_hdr_vec[127:0]), 256'(128'h1111_2222_3333_4444_5555_6666_7777_88AB));
        chk("A_cnt",    phv_cnt, 256'(1));
        idle(2);

        // 3 beats, 70 bytes, with gaps between beats
        keep_tab[0] = 32'hFFFF_FFFF; keep_tab[1] = 32'hFFFF_FFFF; keep_tab[2] = 32'h0000_003F;
        send_pkt(3, 128'hB0B0, 2, 1'b1);
        @(negedge clk);
        chk("B_len",  256'(pkt_hdr_vec[710:704]), 256'(70));
        chk("B_seg3", pkt_hdr_vec[711+768 +: 256], 256'(0));
        idle(2);

        // 4 beats of 32 bytes: 128 saturates to 127
        for (int k = 0; k < 8; k++) keep_tab[k] = 32'hFFFF_FFFF;
        send_pkt(4, 128'hC0C0, 3, 1'b0);
        @(negedge clk);
        chk("C_len", 256'(pkt_hdr_vec[710:704]), 256'(127));
        idle(1);

        // 6-beat packet then a zero-tkeep single beat, back to back
        send_pkt(6, 128'hD0D0, 4, 1'b0);
        keep_tab[0] = 32'h0000_0000;
        send_pkt(1, 128'hE0E0, 5, 1'b0);
        idle(2);

        // back-to-back single-beat packets
        keep_tab[0] = 32'hFFFF_FFFF;
        send_pkt(1, 128'hF1, 6, 1'b0);
        keep_tab[0] = 32'h000F_FFFF;
        send_pkt(1, 128'hF2, 7, 1'b0);
        keep_tab[0] = 32'h0000_0001;
        send_pkt(1, 128'hF3, 8, 1'b0);
        @(negedge clk);
        chk("H_len", 256'(pkt_hdr_vec[710:704]), 256'(1));
        chk("H_cnt", phv_cnt, 256'(8));
        idle(3);

        // reset during beat 1 of a 3-beat packet
        s_axis_tdata  = beat_data(9, 0);
        s_axis_tkeep  = 32'hFFFF_FFFF;
        s_axis_tuser  = 128'h9999;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        @(posedge clk); #1;
        s_axis_tdata  = beat_data(9, 1);
        aresetn       = 1'b0;
        @(posedge clk); #1;
        aresetn       = 1'b1;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("R_valid", 256'(phv_valid), 256'(0));
        chk("R_vec",   256'(|pkt_hdr_vec), 256'(0));
        chk("R_cnt",   phv_cnt, 256'(0));
        idle(1);

        keep_tab[0] = 32'hFFFF_FFFF; keep_tab[1] = 32'h0003_FFFF;
        send_pkt(2, 128'hA5A5, 10, 1'b0);
        @(negedge clk);
        chk("P_len", 256'(pkt_hdr_vec[710:704]), 256'(50));
        chk("P_cnt", phv_cnt, 256'(1));
        idle(4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
